// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
// Package     : common
// Description : Machine width and data-bus request/response types.
// Revision    : 1.0
// ============================================================================
package common;

    localparam int XLEN = 64;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [XLEN-1:0] addr_t;
    typedef logic [2:0]      msize_t;
    typedef logic [7:0]      strobe_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

endpackage
`default_nettype wire

// File: rtl/pipes_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipes
// Description : Decoded ops, stage payload structs, memory FSM states and
//               access size/strobe constants with small decode helpers.
// Revision    : 1.0
// ============================================================================
package pipes;
    import common::*;

    typedef enum logic [4:0] {
        UNKNOWN, ADD, SUB, AND, OR, XOR,
        LB, LH, LW, LD, LBU, LHU, LWU,
        SB, SH, SW, SD
    } decoded_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam msize_t  c_size_byte   = 3'd0;
    localparam msize_t  c_size_half   = 3'd1;
    localparam msize_t  c_size_word   = 3'd2;
    localparam msize_t  c_size_double = 3'd3;

    localparam strobe_t c_strobe_byte   = 8'h01;
    localparam strobe_t c_strobe_half   = 8'h03;
    localparam strobe_t c_strobe_word   = 8'h0F;
    localparam strobe_t c_strobe_double = 8'hFF;

    typedef struct packed {
        addr_t       pc;
        logic [31:0] instruction;
        decoded_op_t op;
        logic        jump;
        logic        regwrite;
        logic [4:0]  dst;
        word_t       aluout;
        word_t       memdata;
    } execute_data_t;

    typedef struct packed {
        addr_t       pc;
        logic [31:0] instruction;
        decoded_op_t op;
        logic        jump;
        logic        regwrite;
        logic [4:0]  dst;
        word_t       regdata;
    } memory_data_t;

    function automatic logic is_load(decoded_op_t op);
        return op inside {LB, LH, LW, LD, LBU, LHU, LWU};
    endfunction

    function automatic logic is_store(decoded_op_t op);
        return op inside {SB, SH, SW, SD};
    endfunction

    function automatic msize_t op_size(decoded_op_t op);
        case (op)
            LB, LBU, SB: return c_size_byte;
            LH, LHU, SH: return c_size_half;
            LW, LWU, SW: return c_size_word;
            default:     return c_size_double;
        endcase
    endfunction

    function automatic strobe_t size_strobe(msize_t size);
        case (size)
            c_size_byte: return c_strobe_byte;
            c_size_half: return c_strobe_half;
            c_size_word: return c_strobe_word;
            default:     return c_strobe_double;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_align_mask(msize_t size);
        case (size)
            c_size_byte: return 3'b000;
            c_size_half: return 3'b001;
            c_size_word: return 3'b011;
            default:     return 3'b111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/memdata_align.sv
`default_nettype none
// ============================================================================
// Module      : memdata_align
// Description : Combinational store lane alignment and load byte extraction
//               with sign/zero extension.
// Revision    : 1.0
// ============================================================================
module memdata_align
    import common::*;
    import pipes::*;
(
    input  decoded_op_t op,
    input  logic [2:0]  offset,
    input  word_t       store_data,
    input  word_t       load_data,
    output msize_t      size,
    output strobe_t     strobe,
    output word_t       wdata,
    output word_t       rdata
);

    word_t w_shifted;

    always_comb begin
        size      = op_size(op);
        strobe    = size_strobe(size) << offset;
        wdata     = store_data << {offset, 3'b000};
        w_shifted = load_data >> {offset, 3'b000};
        case (op)
            LB:      rdata = {{56{w_shifted[7]}},  w_shifted[7:0]};
            LBU:     rdata = {56'd0,               w_shifted[7:0]};
            LH:      rdata = {{48{w_shifted[15]}}, w_shifted[15:0]};
            LHU:     rdata = {48'd0,               w_shifted[15:0]};
            LW:      rdata = {{32{w_shifted[31]}}, w_shifted[31:0]};
            LWU:     rdata = {32'd0,               w_shifted[31:0]};
            default: rdata = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memory.sv
`default_nettype none
// ============================================================================
// Module      : memory
// Description : Memory pipeline stage; issues one data-bus access per load or
//               store through an IDLE/BUSY/DONE handshake. Optional macro
//               MEM_MISALIGN_CHECK_EN rejects misaligned accesses.
// Revision    : 1.0
// ============================================================================
module memory
    import common::*;
    import pipes::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    output memory_data_t  dataM,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output logic          stallM,
    output logic          misalignM
);

    mem_state_t state_q, state_d;
    addr_t      addr_q, addr_d;
    msize_t     size_q, size_d;
    strobe_t    strobe_q, strobe_d;
    word_t      wdata_q, wdata_d;
    word_t      rdata_q, rdata_d;

    logic       w_is_mem;
    logic       w_misalign;
    logic [2:0] w_offset;
    msize_t     w_size;
    strobe_t    w_strobe;
    word_t      w_wdata;
    word_t      w_load;
    logic       w_unused_addr_ok;

    assign w_is_mem         = is_load(dataE.op) || is_store(dataE.op);
    assign w_offset         = (state_q == DONE) ? addr_q[2:0] : dataE.aluout[2:0];
    assign w_unused_addr_ok = dresp.addr_ok;

    memdata_align u_align (
        .op         (dataE.op),
        .offset     (w_offset),
        .store_data (dataE.memdata),
        .load_data  (rdata_q),
        .size       (w_size),
        .strobe     (w_strobe),
        .wdata      (w_wdata),
        .rdata      (w_load)
    );

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_misalign = w_is_mem && ((dataE.aluout[2:0] & size_align_mask(w_size)) != 3'b000);
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;

        dataM.pc          = dataE.pc;
        dataM.instruction = dataE.instruction;
        dataM.op          = dataE.op;
        dataM.jump        = dataE.jump;
        dataM.regwrite    = dataE.regwrite;
        dataM.dst         = dataE.dst;
        dataM.regdata     = dataE.aluout;
        stallM            = 1'b0;
        misalignM         = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_is_mem) begin
                    dataM.regwrite = 1'b0;
                    if (w_misalign) begin
                        misalignM = 1'b1;
                    end else begin
                        stallM   = 1'b1;
                        addr_d   = dataE.aluout;
                        size_d   = w_size;
                        strobe_d = w_strobe;
                        wdata_d  = w_wdata;
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                stallM         = 1'b1;
                dataM.regwrite = 1'b0;
                if (dresp.data_ok) begin
                    rdata_d = dresp.data;
                    state_d = DONE;
                end
            end
            DONE: begin
                // dataE is still the op that was issued: upstream held it.
                if (is_store(dataE.op)) begin
                    dataM.regwrite = 1'b0;
                end else if (is_load(dataE.op)) begin
                    dataM.regdata = w_load;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dreq.valid  = (state_q == BUSY);
        dreq.addr   = addr_q;
        dreq.size   = size_q;
        dreq.strobe = strobe_q;
        dreq.data   = wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory
// Description : Self-checking bench for the memory stage with randomized
//               loads/stores checked against a byte-lane reference model.
// Revision    : 1.0
// ============================================================================
module tb_memory;
    import common::*;
    import pipes::*;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t dataE;
    memory_data_t  dataM;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    logic          stallM;
    logic          misalignM;

    int n_checks = 0;
    int n_pass   = 0;

    execute_data_t nop_e;

    memory dut (
        .clk       (clk),
        .reset     (reset),
        .dataE     (dataE),
        .dataM     (dataM),
        .dreq      (dreq),
        .dresp     (dresp),
        .stallM    (stallM),
        .misalignM (misalignM)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int nbytes(decoded_op_t op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, LWU, SW: return 4;
            default:     return 8;
        endcase
    endfunction

    function automatic logic [63:0] model_load(decoded_op_t op, logic [63:0] addr, logic [63:0] d);
        int n;
        int off;
        logic [63:0] v;
        n   = nbytes(op);
        off = int'(addr[2:0]);
        v   = d >> (8 * off);
        if (n < 8) begin
            v = v & ((64'd1 << (8 * n)) - 64'd1);
            if ((op == LB || op == LH || op == LW) && v[8*n-1])
                v = v - (64'd1 << (8 * n));
        end
        return v;
    endfunction

    function automatic logic [7:0] model_strobe(decoded_op_t op, logic [63:0] addr);
        logic [15:0] s;
        s = ((16'd1 << nbytes(op)) - 16'd1) << addr[2:0];
        return s[7:0];
    endfunction

    function automatic logic [2:0] model_size(decoded_op_t op);
        return 3'($clog2(nbytes(op)));
    endfunction

    function automatic execute_data_t mk_exec(decoded_op_t op, logic [63:0] alu, logic [63:0] md, logic rw);
        execute_data_t e;
        e.pc          = {32'h0, $urandom()};
        e.instruction = $urandom();
        e.op          = op;
        e.jump        = 1'b0;
        e.regwrite    = rw;
        e.dst         = 5'($urandom_range(1, 31));
        e.aluout      = alu;
        e.memdata     = md;
        return e;
    endfunction

    // Drives one memory op to completion and reports what the bus and stage showed.
    task automatic do_mem(input decoded_op_t op, input logic [63:0] addr, input logic [63:0] md,
                          input logic [63:0] rd, input int lat,
                          output int stall_cyc, output int valid_cyc, output logic held,
                          output logic bubble_ok, output logic mis_seen, output logic timeout,
                          output logic [63:0] req_addr, output logic [63:0] req_data,
                          output logic [7:0] req_strb, output logic [2:0] req_size,
                          output logic [63:0] regdata, output logic regwrite);
        logic done;
        stall_cyc = 0; valid_cyc = 0; held = 1'b1; bubble_ok = 1'b1; mis_seen = 1'b0; done = 1'b0;
        req_addr = '0; req_data = '0; req_strb = '0; req_size = '0; regdata = '0; regwrite = 1'b0;
        dataE = mk_exec(op, addr, md, 1'b1);
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            mis_seen |= misalignM;
            if (dreq.valid) begin
                if (valid_cyc == 0) begin
                    req_addr = dreq.addr; req_data = dreq.data;
                    req_strb = dreq.strobe; req_size = dreq.size;
                end else if (dreq.addr !== req_addr || dreq.data !== req_data ||
                             dreq.strobe !== req_strb || dreq.size !== req_size) begin
                    held = 1'b0;
                end
                valid_cyc++;
                if (valid_cyc == lat) begin
                    dresp.data_ok = 1'b1;
                    dresp.data    = rd;
                end
            end
            if (stallM) begin
                stall_cyc++;
                if (dataM.regwrite !== 1'b0) bubble_ok = 1'b0;
            end else begin
                done     = 1'b1;
                regdata  = dataM.regdata;
                regwrite = dataM.regwrite;
            end
            @(posedge clk); #1;
            dresp.data_ok = 1'b0;
            dresp.data    = {$urandom(), $urandom()};
        end
        timeout = !done;
        dataE   = nop_e;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        dataE = nop_e;
        dresp = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_checks++; if (stallM !== 1'b0) $display("FAIL reset_stall got %b want 0", stallM); else n_pass++;
        n_checks++; if (dreq.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", dreq.valid); else n_pass++;
        n_checks++; if (misalignM !== 1'b0) $display("FAIL reset_misalign got %b want 0", misalignM); else n_pass++;
        n_checks++; if (dreq.strobe !== 8'h00 || dreq.addr !== 64'h0)
            $display("FAIL reset_req_regs got strobe %h addr %h want 0 0", dreq.strobe, dreq.addr); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough();
        decoded_op_t alu_ops [5] = '{ADD, SUB, AND, OR, XOR};
        for (int i = 0; i < 8; i++) begin
            logic [63:0] a;
            logic rw;
            decoded_op_t op;
            a  = (i == 0) ? 64'h1234 : {$urandom(), $urandom()};
            op = (i == 0) ? ADD : alu_ops[$urandom_range(0, 4)];
            rw = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            dataE = mk_exec(op, a, {$urandom(), $urandom()}, rw);
            #1;
            n_checks++; if (dataM.regdata !== a) $display("FAIL pass_regdata[%0d] got %h want %h", i, dataM.regdata, a); else n_pass++;
            n_checks++; if (stallM !== 1'b0 || dreq.valid !== 1'b0)
                $display("FAIL pass_stall[%0d] got stall %b valid %b want 0 0", i, stallM, dreq.valid); else n_pass++;
            n_checks++; if (dataM.regwrite !== rw || dataM.pc !== dataE.pc || dataM.dst !== dataE.dst)
                $display("FAIL pass_fields[%0d] got rw %b pc %h dst %0d want %b %h %0d", i,
                         dataM.regwrite, dataM.pc, dataM.dst, rw, dataE.pc, dataE.dst); else n_pass++;
            @(posedge clk); #1;
        end
        dataE = nop_e;
    endtask

    task automatic check_load(input decoded_op_t op, input logic [63:0] addr, input logic [63:0] rd, input int lat);
        int sc, vc;
        logic held, bub, mis, to, rw;
        logic [63:0] ra, rdat, rg, exp;
        logic [7:0] rs;
        logic [2:0] rz;
        exp = model_load(op, addr, rd);
        do_mem(op, addr, {$urandom(), $urandom()}, rd, lat, sc, vc, held, bub, mis, to, ra, rdat, rs, rz, rg, rw);
        n_checks++; if (to) $display("FAIL load_timeout %s addr %h got timeout want completion", op.name(), addr); else n_pass++;
        n_checks++; if (rg !== exp) $display("FAIL load_regdata %s addr %h got %h want %h", op.name(), addr, rg, exp); else n_pass++;
        n_checks++; if (sc != lat + 1 || vc != lat)
            $display("FAIL load_timing %s got stall %0d valid %0d want %0d %0d", op.name(), sc, vc, lat + 1, lat); else n_pass++;
        n_checks++; if (ra !== addr || rz !== model_size(op) || !held || !bub || rw !== 1'b1 || mis !== 1'b0)
            $display("FAIL load_req %s got addr %h size %0d held %b bubble %b rw %b mis %b want %h %0d 1 1 1 0",
                     op.name(), ra, rz, held, bub, rw, mis, addr, model_size(op)); else n_pass++;
    endtask

    task automatic test_load();
        decoded_op_t lds [7] = '{LB, LH, LW, LD, LBU, LHU, LWU};
        check_load(LB,  64'h1003, 64'h00000000_80000000, 1);
        check_load(LWU, 64'h10,   64'hFFFFFFFF_87654321, 2);
        for (int i = 0; i < 14; i++) begin
            decoded_op_t op;
            logic [63:0] a;
            op = lds[$urandom_range(0, 6)];
            a  = {$urandom(), $urandom()} & ~64'(nbytes(op) - 1);
            check_load(op, a, {$urandom(), $urandom()}, $urandom_range(1, 4));
        end
    endtask

    task automatic check_store(input decoded_op_t op, input logic [63:0] addr, input logic [63:0] md, input int lat);
        int sc, vc;
        logic held, bub, mis, to, rw;
        logic [63:0] ra, rdat, rg, exp_data;
        logic [7:0] rs, exp_strb;
        logic [2:0] rz;
        exp_strb = model_strobe(op, addr);
        exp_data = md << (8 * int'(addr[2:0]));
        do_mem(op, addr, md, {$urandom(), $urandom()}, lat, sc, vc, held, bub, mis, to, ra, rdat, rs, rz, rg, rw);
        n_checks++; if (to) $display("FAIL store_timeout %s addr %h got timeout want completion", op.name(), addr); else n_pass++;
        n_checks++; if (rs !== exp_strb || rdat !== exp_data)
            $display("FAIL store_lanes %s addr %h got strobe %h data %h want %h %h", op.name(), addr, rs, rdat, exp_strb, exp_data); else n_pass++;
        n_checks++; if (sc != lat + 1 || vc != lat || !held)
            $display("FAIL store_timing %s got stall %0d valid %0d held %b want %0d %0d 1", op.name(), sc, vc, held, lat + 1, lat); else n_pass++;
        n_checks++; if (ra !== addr || rz !== model_size(op) || rw !== 1'b0 || !bub)
            $display("FAIL store_req %s got addr %h size %0d rw %b bubble %b want %h %0d 0 1",
                     op.name(), ra, rz, rw, bub, addr, model_size(op)); else n_pass++;
    endtask

    task automatic test_store();
        decoded_op_t sts [4] = '{SB, SH, SW, SD};
        check_store(SH, 64'h2006, 64'hBEEF, 5);
        for (int i = 0; i < 10; i++) begin
            decoded_op_t op;
            logic [63:0] a;
            op = sts[$urandom_range(0, 3)];
            a  = {$urandom(), $urandom()} & ~64'(nbytes(op) - 1);
            check_store(op, a, {$urandom(), $urandom()}, $urandom_range(1, 4));
        end
    endtask

    task automatic test_reset_busy();
        int v;
        logic seen;
        v = 0;
        seen = 1'b0;
        dataE = mk_exec(LD, 64'h3000, 64'h0, 1'b1);
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (dreq.valid) v++;
            if (v == 2) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++; if (!seen) $display("FAIL rstbusy_reach got valid cycles %0d want 2", v); else n_pass++;
        reset = 1'b1;
        dataE = nop_e;
        @(posedge clk); #1;
        reset = 1'b0;
        dresp.data_ok = 1'b1;
        dresp.data    = {$urandom(), $urandom()};
        #1;
        n_checks++; if (dreq.valid !== 1'b0 || stallM !== 1'b0)
            $display("FAIL rstbusy_after got valid %b stall %b want 0 0", dreq.valid, stallM); else n_pass++;
        @(posedge clk); #1;
        dresp.data_ok = 1'b0;
        #1;
        n_checks++; if (dreq.valid !== 1'b0 || stallM !== 1'b0)
            $display("FAIL rstbusy_late_ok got valid %b stall %b want 0 0", dreq.valid, stallM); else n_pass++;
        check_load(LH, 64'h4002, 64'h0000_8001_0000_0000, 2);
    endtask

    task automatic test_misalign();
        logic [63:0] rd;
        rd = 64'h1122_3344_5566_7788;
`ifdef MEM_MISALIGN_CHECK_EN
        begin
            logic rose;
            rose = 1'b0;
            dataE = mk_exec(LW, 64'h1002, 64'h0, 1'b1);
            #1;
            n_checks++; if (misalignM !== 1'b1 || stallM !== 1'b0 || dataM.regwrite !== 1'b0)
                $display("FAIL misalign_flag got mis %b stall %b rw %b want 1 0 0", misalignM, stallM, dataM.regwrite); else n_pass++;
            @(posedge clk); #1;
            dataE = nop_e;
            for (int c = 0; c < 4; c++) begin
                #1;
                if (dreq.valid) rose = 1'b1;
                @(posedge clk); #1;
            end
            n_checks++; if (rose) $display("FAIL misalign_novalid got valid 1 want 0"); else n_pass++;
        end
`else
        begin
            int sc, vc;
            logic held, bub, mis, to, rw;
            logic [63:0] ra, rdat, rg;
            logic [7:0] rs;
            logic [2:0] rz;
            do_mem(LW, 64'h1002, 64'h0, rd, 2, sc, vc, held, bub, mis, to, ra, rdat, rs, rz, rg, rw);
            n_checks++; if (to || vc != 2 || ra !== 64'h1002)
                $display("FAIL misalign_issue got timeout %b valid %0d addr %h want 0 2 1002", to, vc, ra); else n_pass++;
            n_checks++; if (mis !== 1'b0 || rg !== model_load(LW, 64'h1002, rd))
                $display("FAIL misalign_result got mis %b regdata %h want 0 %h", mis, rg, model_load(LW, 64'h1002, rd)); else n_pass++;
        end
`endif
    endtask

    task automatic test_back_to_back();
        check_load(LD, 64'h8000, 64'hDEAD_BEEF_0123_4567, 1);
        check_store(SB, 64'h8005, 64'hA5, 1);
        check_load(LBU, 64'h8007, 64'hF0FF_FFFF_FFFF_FFFF, 3);
        dataE = mk_exec(XOR, 64'h55AA, 64'h0, 1'b1);
        #1;
        n_checks++; if (dataM.regdata !== 64'h55AA || stallM !== 1'b0 || dataM.regwrite !== 1'b1)
            $display("FAIL b2b_alu got regdata %h stall %b rw %b want 55aa 0 1", dataM.regdata, stallM, dataM.regwrite); else n_pass++;
        @(posedge clk); #1;
        dataE = nop_e;
    endtask

    initial begin
        nop_e = mk_exec(UNKNOWN, 64'h0, 64'h0, 1'b0);
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_reset_busy();
        test_misalign();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 The module SHALL have no parameters; XLEN=64, the bus types and the stage structs SHALL come from packages common and pipes.
REQ-002 clk  input  1  stage clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 dataE  input  execute_data_t  execute-stage result: pc, instruction, op, jump, regwrite, dst, aluout (address or result), memdata (store data).
REQ-005 dataM  output  memory_data_t  result to writeback: pc, instruction, op, jump, regwrite, dst, regdata.
REQ-006 dreq  output  dbus_req_t  data-bus request: valid, addr, size, strobe[7:0], data.
REQ-007 dresp  input  dbus_resp_t  data-bus response: addr_ok, data_ok, data.
REQ-008 stallM  output  1  high while a memory access is outstanding; upstream SHALL hold dataE stable while it is high.
REQ-009 misalignM  output  1  misaligned-access flag (see Configuration).

Function
REQ-010 Non-memory ops SHALL pass through combinationally in 0 cycles: dataM fields copied from dataE, regdata=aluout, stallM=0.
REQ-011 FSM states SHALL be IDLE, BUSY, DONE.
REQ-012 IDLE + memory op: stallM=1; register addr/size/strobe/data; next state BUSY.
REQ-013 BUSY: dreq.valid=1 with all request fields held constant; stallM=1; on dresp.data_ok capture dresp.data and go to DONE, otherwise stay in BUSY.
REQ-014 DONE: dreq.valid=0, stallM=0, dataM presents the completed op; next state IDLE.
REQ-015 A memory op SHALL take at least 3 cycles (IDLE, BUSY, DONE); each extra BUSY cycle adds one cycle.
REQ-016 While stallM=1, dataM.regwrite SHALL be 0 (bubble).
REQ-017 Loads LB/LH/LW/LD SHALL sign-extend and LBU/LHU/LWU SHALL zero-extend the bytes at addr[2:0] of dresp.data into regdata.
REQ-018 Stores SB/SH/SW/SD SHALL drive strobe 0x01/0x03/0x0F/0xFF shifted left by addr[2:0], with data shifted left by 8*addr[2:0].
REQ-019 Stores SHALL set dataM.regwrite=0; loads SHALL keep dataE.regwrite.
REQ-020 dreq.size SHALL encode byte/half/word/double as 0/1/2/3.
REQ-021 A data_ok arriving in IDLE or DONE SHALL be ignored.
REQ-022 A memory op arriving in the DONE cycle SHALL NOT occur, because upstream only advances once stallM falls; back-to-back memory ops SHALL restart at IDLE.

Reset
REQ-023 Reset SHALL force state IDLE, clear all request and capture registers, dreq.valid=0, stallM=0 and misalignM=0 in the following cycle.
REQ-024 Reset in BUSY SHALL abandon the access; the bus shares the reset and SHALL be reset with the stage, so no response is drained.

Configuration
REQ-025 Macro MEM_MISALIGN_CHECK_EN defined: an access whose addr is not a multiple of its size SHALL NOT enter BUSY, and SHALL produce misalignM=1, dataM.regwrite=0 and stallM=0 for that cycle only.
REQ-026 Macro not defined: misalignM SHALL be tied to 0 and all accesses SHALL be issued as in REQ-012.

Structure
REQ-027 The mem_state_t enum and the size/strobe constants SHALL live in package pipes; dbus types SHALL stay in common.
REQ-028 Load extraction and store alignment SHALL be one combinational sub-module, memdata_align.

Verification
REQ-029 Op ADD with aluout=0x1234: dataM.regdata=0x1234 in the same cycle, and stallM=0.
REQ-030 LB at addr 0x1003, data_ok on the first BUSY cycle, dresp.data=0x00000000_80000000: regdata=0xFFFFFFFF_FFFFFF80, with stallM high for exactly 2 cycles.
REQ-031 SH at addr 0x2006, memdata=0xBEEF: strobe=0xC0 and data=0xBEEF0000_00000000 held for the whole BUSY period; data_ok delayed 5 cycles leaves stallM high for 6 cycles.
REQ-032 LWU at addr 0x10, dresp.data=0xFFFFFFFF_87654321: regdata=0x00000000_87654321.
REQ-033 Reset asserted on the 2nd BUSY cycle: dreq.valid=0 and stallM=0 on the next cycle, and a late data_ok produces no dataM.regwrite.
REQ-034 With MEM_MISALIGN_CHECK_EN, LW at 0x1002: misalignM=1, dreq.valid never rises and regwrite=0; without the macro, dreq.valid rises with addr 0x1002.
